alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 8-bit combinational ALU. Buffers {opcode,A,B} commands in a small FIFO.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_sequencer_if.sv | 33 +++
 rtl/alu_cmd_sequencer_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//   ALU_WIDTH    default operand/result width of the companion ALU
//   alu_op_e     ALU opcode encodings (OP_ADD..OP_XOR); 101-111 are illegal
//   is_legal_op  1 when an opcode is one the ALU implements
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle of the ALU command sequencer.
//   cmd_*  command channel (valid/ready): opcode, operands, chain flag
//   rsp_*  response channel (valid/ready): result, carry, zero, illegal
// Modports: master = command producer / response consumer, slave = sequencer.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_illegal;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous show-ahead command FIFO (head entry visible without a pop).
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry
//   full/empty occupancy flags, level = 0..DEPTH
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DW-1:0]           push_data,
    input  logic                    pop,
    output logic [DW-1:0]           head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of an external combinational 8-bit ALU.
// Commands are queued in a FIFO, issued from registers (alu_a/alu_b/alu_opcode)
// and the ALU output is captured into a valid/ready response register.
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      cmd_* command channel, rsp_* response channel
//   alu_a/b/opcode   registered ALU inputs
//   alu_result/carry combinational ALU outputs
//   fifo_level       command FIFO occupancy 0..DEPTH
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_cmd_sequencer_if.slave     bus,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_opcode,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_carry,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int unsigned EW = 1 + 3 + 2 * WIDTH;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    head_data;
    logic             head_chain;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    logic             s1_valid;
    logic             s1_illegal;
    logic             adv2;
    logic             s1_load;
    logic [WIDTH-1:0] acc;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_illegal;

    // No pass-through: a full FIFO refuses even when it pops this cycle.
    assign bus.cmd_ready = !full && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign push_data     = {bus.cmd_chain, bus.cmd_op, bus.cmd_a, bus.cmd_b};
    assign {head_chain, head_op, head_a, head_b} = head_data;

    assign adv2    = s1_valid && (!rsp_valid || bus.rsp_ready);
    // A chained head waits for an empty s1 so that acc already holds the
    // result of every older command (one bubble per chained op).
    assign s1_load = !empty && (!s1_valid || (adv2 && !head_chain));
    assign pop     = s1_load;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_illegal  <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            acc         <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (s1_load) begin
                alu_a      <= head_chain ? acc : head_a;
                alu_b      <= head_b;
                alu_opcode <= head_op;
                s1_illegal <= !is_legal_op(head_op);
                s1_valid   <= 1'b1;
            end else if (adv2) begin
                s1_valid   <= 1'b0;
            end

            if (adv2) begin
                rsp_valid   <= 1'b1;
                rsp_result  <= alu_result;
                rsp_carry   <= alu_carry;
                rsp_zero    <= (alu_result == '0);
                rsp_illegal <= s1_illegal;
                if (!s1_illegal) begin
                    acc <= alu_result;
                end
            end else if (bus.rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = rsp_result;
    assign bus.rsp_carry   = rsp_carry;
    assign bus.rsp_zero    = rsp_zero;
    assign bus.rsp_illegal = rsp_illegal;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU alongside.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_opcode;
    logic         alu_carry;
    logic [$clog2(DEPTH):0] fifo_level;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

    alu_cmd_sequencer #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .fifo_level (fifo_level)
    );

    // Companion combinational ALU
    always_comb begin
        {alu_carry, alu_result} = '0;
        case (alu_opcode)
            3'b000:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: {alu_carry, alu_result} = '0;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: responses computed in command order at acceptance time
    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       illegal;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] macc = '0;

    function automatic rsp_t ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        int   s;
        r = '0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r.result = 8'(s % 256); r.carry = (s > 255); end
            3'd1: begin s = int'(a) - int'(b); if (s < 0) s += 256; r.result = 8'(s); end
            3'd2: r.result = a & b;
            3'd3: r.result = a | b;
            3'd4: r.result = a ^ b;
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == 8'd0);
        return r;
    endfunction

    rsp_t       mon_e, mon_r;
    logic [7:0] mon_a;

    // Handshakes observed mid-cycle take effect at the following rising edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            macc = '0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("model_rsp",
                          32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal}),
                          32'(mon_e));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                mon_a = bus.cmd_chain ? macc : bus.cmd_a;
                mon_r = ref_op(bus.cmd_op, mon_a, bus.cmd_b);
                if (!mon_r.illegal) macc = mon_r.result;
                exp_q.push_back(mon_r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_chain = chain;
    endtask

    task automatic check_rsp(input string name, input logic [7:0] res, input logic c, input logic z, input logic il);
        check({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({name, "_result"}, 32'(bus.rsp_result), 32'(res));
        check({name, "_flags"}, 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal}), 32'({c, z, il}));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       illegal;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         accepted;
        logic [7:0] snap;

        // op, a, b, chain, result, carry, zero, illegal (acc carries across rows)
        tbl[0]  = '{3'd0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 8'd5,   8'd5,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[2]  = '{3'd4, 8'hF0,  8'h0F,  1'b0, 8'hFF,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd0, 8'd10,  8'd20,  1'b0, 8'd30,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd0, 8'd99,  8'd5,   1'b1, 8'd35,  1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd3, 8'd0,   8'h40,  1'b1, 8'h63,  1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'd6, 8'd3,   8'd4,   1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        tbl[7]  = '{3'd0, 8'd77,  8'd1,   1'b1, 8'h64,  1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd2, 8'hAA,  8'h0F,  1'b0, 8'h0A,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'd1, 8'd3,   8'd5,   1'b0, 8'hFE,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd0, 8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b1, 1'b0};
        tbl[11] = '{3'd7, 8'd1,   8'd9,   1'b1, 8'h00,  1'b0, 1'b1, 1'b1};
        tbl[12] = '{3'd4, 8'd0,   8'h5A,  1'b1, 8'h5A,  1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_regs", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // Table-driven single commands with latency check
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            set_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chain);
            tick();
            bus.cmd_valid = 1'b0;
            cnt = 0;
            while (!bus.rsp_valid && cnt < 8) begin
                tick();
                cnt++;
            end
            check("tbl_latency", 32'(cnt), 32'd2);
            check_rsp("tbl", tbl[i].res, tbl[i].carry, tbl[i].zero, tbl[i].illegal);
            tick();
        end

        // Back-to-back sub then xor on consecutive cycles
        set_cmd(3'd1, 8'd5, 8'd5, 1'b0);
        tick();
        set_cmd(3'd4, 8'hF0, 8'h0F, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check_rsp("b2b_first", 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_rsp("b2b_second", 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();

        // Chain: exactly one bubble before each chained issue
        set_cmd(3'd0, 8'd10, 8'd20, 1'b0);
        tick();
        set_cmd(3'd0, 8'd0, 8'd5, 1'b1);
        tick();
        set_cmd(3'd3, 8'd0, 8'h40, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        check_rsp("chain0", 8'd30, 1'b0, 1'b0, 1'b0);
        tick();
        check("chain_bubble1", 32'(bus.rsp_valid), 32'd0);
        tick();
        check_rsp("chain1", 8'd35, 1'b0, 1'b0, 1'b0);
        tick();
        check("chain_bubble2", 32'(bus.rsp_valid), 32'd0);
        tick();
        check_rsp("chain2", 8'h63, 1'b0, 1'b0, 1'b0);
        tick();

        // Backpressure: 4 FIFO + s1 + response register = 6 accepted
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int k = 1; k <= 10; k++) begin
            set_cmd(3'd0, 8'(k * 16), 8'(k), 1'b0);
            #1;
            if (bus.cmd_ready) accepted++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        #1;
        check("bp_accepted", 32'(accepted), 32'd6);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_level", 32'(fifo_level), 32'(DEPTH));
        check_rsp("bp_head", 8'd17, 1'b0, 1'b0, 1'b0);
        snap = bus.rsp_result;
        repeat (3) tick();
        check("bp_stable", 32'({bus.rsp_valid, bus.rsp_result}), 32'({1'b1, snap}));
        bus.rsp_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && cnt < 40) begin
            tick();
            cnt++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset: 3 queued, 1 in s1, 1 response pending
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_cmd(3'd0, 8'(k + 1), 8'd2, 1'b0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        #1;
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_rsp", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal}), 32'd0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        // Accumulator restarts from zero
        set_cmd(3'd0, 8'd50, 8'd7, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check_rsp("acc_after_rst", 8'd7, 1'b0, 1'b0, 1'b0);
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            bus.cmd_op    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            bus.cmd_a     = 8'($urandom);
            bus.cmd_b     = 8'($urandom);
            bus.cmd_chain = ($urandom_range(0, 2) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && cnt < 100) begin
            tick();
            cnt++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_level_empty", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
